// File: rtl/opacc_seq_if.sv
// Command, input-beat and drain-row streams between the MPU side and opacc_seq.
interface opacc_seq_if #(
  parameter int nregs = 2,
  parameter int vl    = 4,
  parameter int ml    = 4,
  parameter int XLEN  = 64,
  parameter int LW    = 16
) ();
  localparam int RW = (nregs > 1) ? $clog2(nregs) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [RW-1:0]        cmd_reg;
  logic [LW-1:0]        cmd_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [ml*XLEN-1:0]   in_a;
  logic [vl*XLEN-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [vl*XLEN-1:0]   out_row;
  logic                 done;
  logic                 busy;

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_len, in_valid, in_a, in_b, out_ready,
    input  cmd_ready, in_ready, out_valid, out_row, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_len, in_valid, in_a, in_b, out_ready,
    output cmd_ready, in_ready, out_valid, out_row, done, busy
  );
endinterface

// File: rtl/opacc_seq.sv
// Sequencer driving the outer-product accumulator's register-file port:
// tile load, A/B MAC streaming, tile zeroing and row-by-row drain.
module opacc_seq #(
  parameter int nregs = 2,
  parameter int vl    = 4,
  parameter int ml    = 4,
  parameter int XLEN  = 64,
  parameter int LW    = 16,
  localparam int RW   = (nregs > 1) ? $clog2(nregs) : 1
) (
  input  logic               clk,
  input  logic               reset,
  opacc_seq_if.slave         bus,
  output logic               o_opc_c_valid,
  output logic               o_opc_ab_valid,
  output logic [RW-1:0]      o_opc_ci_addr,
  output logic [RW-1:0]      o_opc_ab_addr,
  output logic [ml*XLEN-1:0] o_opc_ai,
  output logic [vl*XLEN-1:0] o_opc_bi,
  output logic [vl*XLEN-1:0] o_opc_ci,
  input  logic [vl*XLEN-1:0] i_opc_co
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_ZERO, S_STORE, S_SBUB, S_FLUSH
  } state_t;

  localparam logic [LW-1:0] ML_LAST = LW'(ml - 1);
  localparam logic [LW-1:0] ML_ROWS = LW'(ml);

  state_t             r_state, w_state;
  logic [LW-1:0]      r_cnt, w_cnt;
  logic [LW-1:0]      r_len, w_len;
  logic [RW-1:0]      r_tile, w_tile;
  logic               r_c_valid, w_c_valid;
  logic               r_ab_valid, w_ab_valid;
  logic [ml*XLEN-1:0] r_ai, w_ai;
  logic [vl*XLEN-1:0] r_bi, w_bi;
  logic [vl*XLEN-1:0] r_ci, w_ci;
  logic               w_cmd_ready, w_in_ready, w_out_valid, w_done;

  // The counter compares against len-1 on the final beat, so a MAC of 2^LW-1 never wraps.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_tile      = r_tile;
    w_c_valid   = 1'b0;
    w_ab_valid  = 1'b0;
    w_ai        = r_ai;
    w_bi        = r_bi;
    w_ci        = r_ci;
    w_cmd_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_tile = bus.cmd_reg;
          w_cnt  = '0;
          w_len  = bus.cmd_len;
          case (bus.cmd_op)
            2'd0: w_state = S_LOAD;
            2'd1: begin
              if (bus.cmd_len == '0) w_state = S_FLUSH;
              else                   w_state = S_MAC;
            end
            2'd2:    w_state = S_STORE;
            default: w_state = S_ZERO;
          endcase
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_c_valid = 1'b1;
          w_ci      = bus.in_b;
          w_cnt     = r_cnt + LW'(1);
          if (r_cnt == ML_LAST) w_state = S_FLUSH;
        end
      end
      S_MAC: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ab_valid = 1'b1;
          w_ai       = bus.in_a;
          w_bi       = bus.in_b;
          w_cnt      = r_cnt + LW'(1);
          if (r_cnt == r_len - LW'(1)) w_state = S_FLUSH;
        end
      end
      S_ZERO: begin
        w_c_valid = 1'b1;
        w_ci      = '0;
        w_cnt     = r_cnt + LW'(1);
        if (r_cnt == ML_LAST) w_state = S_FLUSH;
      end
      S_STORE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_c_valid = 1'b1;
          w_ci      = '0;
          w_cnt     = r_cnt + LW'(1);
          w_state   = S_SBUB;
        end
      end
      S_SBUB: begin
        if (r_cnt == ML_ROWS) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_state = S_STORE;
        end
      end
      S_FLUSH: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_tile     <= '0;
      r_c_valid  <= 1'b0;
      r_ab_valid <= 1'b0;
      r_ai       <= '0;
      r_bi       <= '0;
      r_ci       <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_tile     <= w_tile;
      r_c_valid  <= w_c_valid;
      r_ab_valid <= w_ab_valid;
      r_ai       <= w_ai;
      r_bi       <= w_bi;
      r_ci       <= w_ci;
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_row    = w_out_valid ? i_opc_co : '0;
  assign bus.done       = w_done;
  assign bus.busy       = (r_state != S_IDLE);

  assign o_opc_c_valid  = r_c_valid;
  assign o_opc_ab_valid = r_ab_valid;
  assign o_opc_ci_addr  = r_tile;
  assign o_opc_ab_addr  = r_tile;
  assign o_opc_ai       = r_ai;
  assign o_opc_bi       = r_bi;
  assign o_opc_ci       = r_ci;
endmodule

// File: tb/tb_opacc_seq.sv
// Self-checking bench for opacc_seq: an accumulator model answers opc_co, and a
// store-order tile model predicts every drained row, done timing and strobe counts.
module tb_opacc_seq;
  localparam int nregs  = 2;
  localparam int vl     = 4;
  localparam int ml     = 4;
  localparam int XLEN   = 64;
  localparam int LW     = 16;
  localparam int RW     = 1;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  opacc_seq_if #(.nregs(nregs), .vl(vl), .ml(ml), .XLEN(XLEN), .LW(LW)) bus ();

  logic               opcCValid, opcAbValid;
  logic [RW-1:0]      opcCiAddr, opcAbAddr;
  logic [ml*XLEN-1:0] opcAi;
  logic [vl*XLEN-1:0] opcBi, opcCi, opcCo;

  opacc_seq #(.nregs(nregs), .vl(vl), .ml(ml), .XLEN(XLEN), .LW(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_opc_c_valid  (opcCValid),
    .o_opc_ab_valid (opcAbValid),
    .o_opc_ci_addr  (opcCiAddr),
    .o_opc_ab_addr  (opcAbAddr),
    .o_opc_ai       (opcAi),
    .o_opc_bi       (opcBi),
    .o_opc_ci       (opcCi),
    .i_opc_co       (opcCo)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bothHigh = 0;

  logic [XLEN-1:0]    acc [nregs][ml][vl];
  longint unsigned    mdl [nregs][ml][vl];
  logic [vl*XLEN-1:0] lastRows [ml];
  logic [ml*XLEN-1:0] qa [$];
  logic [vl*XLEN-1:0] qb [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator: C strobe shifts rows up (row 0 takes opc_ci), AB strobe adds a[i]*b[j].
  always @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < nregs; t++)
        for (int i = 0; i < ml; i++)
          for (int j = 0; j < vl; j++) acc[t][i][j] <= '0;
    end else begin
      if (opcCValid) begin
        for (int j = 0; j < vl; j++) acc[opcCiAddr][0][j] <= opcCi[j*XLEN +: XLEN];
        for (int i = 1; i < ml; i++)
          for (int j = 0; j < vl; j++) acc[opcCiAddr][i][j] <= acc[opcCiAddr][i-1][j];
      end
      if (opcAbValid) begin
        for (int i = 0; i < ml; i++)
          for (int j = 0; j < vl; j++)
            acc[opcAbAddr][i][j] <= acc[opcAbAddr][i][j] + opcAi[i*XLEN +: XLEN] * opcBi[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    opcCo = '0;
    for (int j = 0; j < vl; j++) opcCo[j*XLEN +: XLEN] = acc[opcCiAddr][ml-1][j];
  end

  always @(negedge clk) if (!reset && opcCValid && opcAbValid) bothHigh++;

  function automatic logic [ml*XLEN-1:0] randA();
    logic [ml*XLEN-1:0] v;
    for (int i = 0; i < ml; i++) v[i*XLEN +: XLEN] = {$urandom, $urandom};
    return v;
  endfunction

  function automatic logic [vl*XLEN-1:0] randB();
    logic [vl*XLEN-1:0] v;
    for (int j = 0; j < vl; j++) v[j*XLEN +: XLEN] = {$urandom, $urandom};
    return v;
  endfunction

  function automatic int pickGap(input int mode);
    if (mode == 2) return 3;
    if (mode == 1) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Tile model kept in drain order: index k is the k-th row a STORE emits.
  function automatic void applyBeat(input int op, input int tile, input int beat,
                                    input logic [ml*XLEN-1:0] a, input logic [vl*XLEN-1:0] b);
    if (op == 0) begin
      for (int j = 0; j < vl; j++) mdl[tile][beat][j] = b[j*XLEN +: XLEN];
    end else if (op == 1) begin
      for (int k = 0; k < ml; k++)
        for (int j = 0; j < vl; j++)
          mdl[tile][k][j] += a[(ml-1-k)*XLEN +: XLEN] * b[j*XLEN +: XLEN];
    end
  endfunction

  function automatic logic [vl*XLEN-1:0] mdlRow(input int tile, input int k);
    logic [vl*XLEN-1:0] v;
    for (int j = 0; j < vl; j++) v[j*XLEN +: XLEN] = mdl[tile][k][j];
    return v;
  endfunction

  function automatic void clearTile(input int tile);
    for (int k = 0; k < ml; k++)
      for (int j = 0; j < vl; j++) mdl[tile][k][j] = 0;
  endfunction

  // Issues one command, feeds/drains its streams and checks its outcome.
  task automatic runCmd(input int op, input int tile, input int len, input int gapMode,
                        input int stallMode, input bit hold, output int accCyc, output int doneCyc);
    int rel, beat, rows, lastRel, gapLeft, stallLeft, cCnt, abCnt, addrErr;
    int nBeats, expDone, expC, expAb, expRows, doneRel;
    bit seen, prevStalled, loaded;
    logic [ml*XLEN-1:0] curA;
    logic [vl*XLEN-1:0] curB, stallRow, expRow;
    accCyc = -1;
    doneCyc = -1;
    curA = '0;
    curB = '0;
    stallRow = '0;
    bus.cmd_op = 2'(op);
    bus.cmd_reg = RW'(tile);
    bus.cmd_len = LW'(len);
    bus.cmd_valid = 1'b1;
    for (int w = 0; w < BUDGET; w++) begin
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        accCyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hold) bus.cmd_valid = 1'b0;
    checks++;
    if (accCyc < 0) begin
      errors++;
      $display("[TB] FAIL accept op=%0d: no cmd_ready seen, required within %0d cycles", op, BUDGET);
      return;
    end
    nBeats = (op == 0) ? ml : (op == 1) ? len : 0;
    gapLeft = pickGap(gapMode);
    stallLeft = (stallMode == 2) ? 5 : (stallMode == 1) ? int'($urandom_range(0, 2)) : 0;
    seen = 0; beat = 0; rows = 0; lastRel = 0; cCnt = 0; abCnt = 0; addrErr = 0;
    prevStalled = 0; loaded = 0;
    for (int t = 0; t < BUDGET; t++) begin
      rel = cyc - accCyc + 1;
      if (opcCValid === 1'b1) begin cCnt++; if (opcCiAddr !== RW'(tile)) addrErr++; end
      if (opcAbValid === 1'b1) begin abCnt++; if (opcAbAddr !== RW'(tile)) addrErr++; end
      if (prevStalled) begin
        checks++;
        if (opcCValid !== 1'b0 || bus.out_row !== stallRow) begin
          errors++;
          $display("[TB] FAIL stall_hold: c_valid=%b row=%h, required c_valid=0 row=%h", opcCValid, bus.out_row, stallRow);
        end
      end
      prevStalled = 0;
      if (bus.done === 1'b1) begin
        seen = 1;
        doneCyc = cyc;
        break;
      end
      bus.in_valid = 1'b0;
      if (beat < nBeats) begin
        if (gapLeft > 0) gapLeft--;
        else begin
          if (!loaded) begin
            if (qa.size() > 0) curA = qa.pop_front(); else curA = randA();
            if (qb.size() > 0) curB = qb.pop_front(); else curB = randB();
            loaded = 1;
          end
          bus.in_valid = 1'b1;
          bus.in_a = curA;
          bus.in_b = curB;
          if (bus.in_ready === 1'b1) begin
            applyBeat(op, tile, beat, curA, curB);
            beat++;
            lastRel = rel;
            loaded = 0;
            gapLeft = pickGap(gapMode);
          end
        end
      end
      bus.out_ready = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (op == 2 && stallLeft > 0) begin
          stallLeft--;
          prevStalled = 1;
          stallRow = bus.out_row;
        end else begin
          bus.out_ready = 1'b1;
          if (op == 2 && rows < ml) begin
            expRow = mdlRow(tile, rows);
            checks++;
            if (bus.out_row !== expRow) begin
              errors++;
              $display("[TB] FAIL store_row%0d: got %h, required %h", rows, bus.out_row, expRow);
            end
            lastRows[rows] = bus.out_row;
          end
          rows++;
          lastRel = rel;
          stallLeft = (stallMode == 1) ? int'($urandom_range(0, 2)) : 0;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout op=%0d: no done, required within %0d cycles", op, BUDGET);
      return;
    end
    doneRel = doneCyc - accCyc + 1;
    if (op == 3) expDone = ml + 1;
    else if (gapMode == 0 && stallMode == 0)
      expDone = (op == 0) ? ml + 1 : (op == 1) ? len + 1 : 2 * ml;
    else expDone = lastRel + 1;
    if (doneRel !== expDone) begin
      errors++;
      $display("[TB] FAIL done_time op=%0d: done at T+%0d, required T+%0d", op, doneRel, expDone);
    end
    expC = (op == 1) ? 0 : ml;
    expAb = (op == 1) ? len : 0;
    expRows = (op == 2) ? ml : 0;
    checks++;
    if (cCnt !== expC || abCnt !== expAb || addrErr !== 0) begin
      errors++;
      $display("[TB] FAIL strobes op=%0d: c=%0d ab=%0d addrErr=%0d, required c=%0d ab=%0d addrErr=0",
               op, cCnt, abCnt, addrErr, expC, expAb);
    end
    checks++;
    if (beat !== nBeats || rows !== expRows) begin
      errors++;
      $display("[TB] FAIL beats op=%0d: in=%0d out=%0d, required in=%0d out=%0d", op, beat, rows, nBeats, expRows);
    end
    if (op == 2 || op == 3) clearTile(tile);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_reg = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    for (int t = 0; t < nregs; t++) clearTile(t);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b busy=%b done=%b, required 1 0 0", bus.cmd_ready, bus.busy, bus.done);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_row !== '0) begin
      errors++;
      $display("[TB] FAIL reset_stream: in_ready=%b out_valid=%b, required 0 0 row 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (opcCValid !== 1'b0 || opcAbValid !== 1'b0 || opcCiAddr !== '0 || opcAbAddr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_strobe: c=%b ab=%b, required 0 0 addr 0", opcCValid, opcAbValid);
    end
    checks++;
    if (opcAi !== '0 || opcBi !== '0 || opcCi !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: ai/bi/ci nonzero, required all 0");
    end
    reset = 1'b0;
  endtask

  task automatic test_load_store();
    int a, d;
    logic [vl*XLEN-1:0] want;
    for (int k = 0; k < ml; k++) qb.push_back({vl{64'(k + 1)}});
    runCmd(0, 1, 0, 0, 0, 1'b0, a, d);
    runCmd(2, 1, 0, 0, 0, 1'b0, a, d);
    for (int k = 0; k < ml; k++) begin
      want = {vl{64'(k + 1)}};
      checks++;
      if (lastRows[k] !== want) begin
        errors++;
        $display("[TB] FAIL load_store_row%0d: got %h, required %h", k, lastRows[k], want);
      end
    end
    runCmd(2, 1, 0, 0, 0, 1'b0, a, d);
    for (int k = 0; k < ml; k++) begin
      checks++;
      if (lastRows[k] !== '0) begin
        errors++;
        $display("[TB] FAIL restore_zero_row%0d: got %h, required 0", k, lastRows[k]);
      end
    end
  endtask

  task automatic test_mac();
    int a, d;
    int expv [4] = '{8, 6, 4, 2};
    logic [ml*XLEN-1:0] av;
    logic [vl*XLEN-1:0] want;
    for (int i = 0; i < ml; i++) av[i*XLEN +: XLEN] = 64'(i + 1);
    runCmd(3, 0, 0, 0, 0, 1'b0, a, d);
    repeat (2) begin qa.push_back(av); qb.push_back({vl{64'd1}}); end
    runCmd(1, 0, 2, 0, 0, 1'b0, a, d);
    runCmd(2, 0, 0, 0, 0, 1'b0, a, d);
    for (int k = 0; k < ml; k++) begin
      want = {vl{64'(expv[k])}};
      checks++;
      if (lastRows[k] !== want) begin
        errors++;
        $display("[TB] FAIL mac_row%0d: got %h, required %h", k, lastRows[k], want);
      end
    end
  endtask

  task automatic test_store_stall();
    int a, d;
    runCmd(0, 0, 0, 0, 0, 1'b0, a, d);
    runCmd(2, 0, 0, 0, 2, 1'b0, a, d);
  endtask

  task automatic test_len0_gaps();
    int a, d;
    runCmd(1, 1, 0, 0, 0, 1'b0, a, d);
    runCmd(0, 1, 0, 2, 0, 1'b0, a, d);
    runCmd(2, 1, 0, 0, 0, 1'b0, a, d);
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    bus.cmd_op = 2'd1; bus.cmd_reg = 1'b1; bus.cmd_len = LW'(3); bus.cmd_valid = 1'b1;
    for (int w = 0; w < 20 && bus.cmd_ready !== 1'b1; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = randA(); bus.in_b = randB();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (opcAbValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_beat: ab_valid=%b, required 1", opcAbValid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < nregs; t++) clearTile(t);
    checks++;
    if (opcCValid !== 1'b0 || opcAbValid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset: c=%b ab=%b busy=%b ready=%b, required 0 0 0 1",
               opcCValid, opcAbValid, bus.busy, bus.cmd_ready);
    end
    doneSeen = 0;
    repeat (5) begin
      if (bus.done === 1'b1) doneSeen++;
      @(posedge clk); #1;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL mid_nodone: %0d done pulses, required 0", doneSeen);
    end
  endtask

  task automatic test_back_to_back();
    int ops [5] = '{3, 0, 1, 2, 2};
    int tiles [5] = '{0, 1, 0, 1, 0};
    int lens [5] = '{0, 0, 3, 0, 0};
    int a, d, prevDone;
    prevDone = -1;
    for (int i = 0; i < 5; i++) begin
      runCmd(ops[i], tiles[i], lens[i], 0, 0, 1'b1, a, d);
      if (i > 0) begin
        checks++;
        if (a !== prevDone + 2) begin
          errors++;
          $display("[TB] FAIL b2b_accept%0d: accepted at %0d, required %0d", i, a, prevDone + 2);
        end
      end
      prevDone = d;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    int a, d;
    for (int i = 0; i < 24; i++)
      runCmd(int'($urandom_range(0, 3)), int'($urandom_range(0, nregs - 1)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, a, d);
    runCmd(1, 0, 40, 1, 0, 1'b0, a, d);
    runCmd(2, 0, 0, 0, 1, 1'b0, a, d);
    runCmd(2, 1, 0, 0, 0, 1'b0, a, d);
  endtask

  task automatic test_exclusive();
    checks++;
    if (bothHigh !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_exclusive: %0d cycles with both strobes, required 0", bothHigh);
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_mac();
    test_store_stall();
    test_len0_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/opacc_seq.md
# opacc_seq

Command sequencer that drives the outer-product accumulator's register-file port: it loads C tiles row by row, streams A/B vector pairs for k outer-product steps, zeroes tiles, and drains C tiles row by row to an output stream. It sits between the MPU command/data streams and the accumulator. It is the only initiator of the accumulator's `c_valid`/`ab_valid` strobes, and it never asserts both in the same cycle.

## Interface
- `nregs`, 2: number of accumulator tiles
- `vl`, 4: columns per tile (B/C row length)
- `ml`, 4: rows per tile (A length)
- `XLEN`, 64: element width
- `LW`, 16: width of the MAC step count
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cmd_valid`/`cmd_ready`  in/out  1  command handshake
- `cmd_op`  in  2  0=LOAD, 1=MAC, 2=STORE, 3=ZERO
- `cmd_reg`  in  $clog2(nregs)  target tile
- `cmd_len`  in  LW  MAC step count (ignored otherwise)
- `in_valid`/`in_ready`  in/out  1  input stream handshake
- `in_a`  in  ml*XLEN  A vector (MAC)
- `in_b`  in  vl*XLEN  B vector (MAC) or C row (LOAD)
- `out_valid`/`out_ready`  out/in  1  drain stream handshake
- `out_row`  out  vl*XLEN  drained C row
- `done`  out  1  one-cycle pulse, command complete
- `busy`  out  1  state != IDLE
- `opc_c_valid`, `opc_ab_valid`  out  1  accumulator strobes (registered)
- `opc_ci_addr`, `opc_ab_addr`  out  $clog2(nregs)  tile addresses (registered)
- `opc_ai`  out  ml*XLEN; `opc_bi`, `opc_ci`  out  vl*XLEN  (registered)
- `opc_co`  in  vl*XLEN  accumulator row ml-1 of tile `opc_ci_addr`

## Operation
- States: IDLE, LOAD, MAC, ZERO, STORE, SBUB, FLUSH.
- IDLE: `cmd_ready`=1. Accept on `cmd_valid`: latch reg into both `opc_ci_addr` and `opc_ab_addr`, clear the beat counter, then go to the state for `cmd_op`. MAC with `cmd_len`=0 goes to FLUSH.
- LOAD: `in_ready`=1. Each accepted beat registers `opc_c_valid`=1 and `opc_ci`=`in_b`. After ml beats go to FLUSH. The first row loaded ends at accumulator row ml-1.
- MAC: `in_ready`=1. Each beat registers `opc_ab_valid`=1, `opc_ai`=`in_a`, `opc_bi`=`in_b`. After `cmd_len` beats go to FLUSH.
- ZERO: issues an internal beat every cycle with no handshake (`opc_c_valid`=1, `opc_ci`=0), ml beats, then FLUSH.
- STORE: `out_valid`=1 and `out_row`=`opc_co` (combinational). On handshake, register `opc_c_valid`=1 with `opc_ci`=0 (pop plus zero-fill), count the row, and go to SBUB. Rows leave in accumulator-row order ml-1 down to 0, so LOAD order equals STORE order.
- SBUB: one bubble cycle with `out_valid`=0 while the pop lands. Go back to STORE if rows remain, else IDLE with `done`=1.
- FLUSH: one cycle while the last registered strobe lands, `done`=1, then IDLE.
- `opc_*` strobes default to 0 every cycle they are not issued. Data/addr registers hold their values.
- `in_ready`=0 outside LOAD/MAC. `out_valid`=0 outside STORE. Commands in IDLE only.
- The beat counter is LW bits wide. A MAC of 2^LW-1 steps must complete without wrap.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 except `cmd_ready`=1. Reset mid-command abandons it with no `done` pulse.
- Command accepted at T; LOAD/MAC/ZERO/STORE active from T+1.
- A beat accepted in cycle t: strobe high in t+1, accumulator updated at the end of t+1.
- LOAD/MAC with no stalls: last beat at T+N, FLUSH at T+N+1 (`done`), IDLE at T+N+2. The accumulator is final by then.
- ZERO: `done` at T+ml+1.
- STORE: throughput 1 row per 2 cycles. Unstalled `done` at T+2ml.
- `in_valid` gaps and `out_ready` stalls pause the sequence with no beat loss. `out_row` stays stable while `out_valid`&&!`out_ready`.

## Test plan
- LOAD reg1 rows with all lanes 1,2,3,4, then STORE reg1 → out rows 1,2,3,4 in order, `done` each. A second STORE reg1 → four all-zero rows.
- ZERO reg0; MAC reg0 len 2 with a=(1,2,3,4), b=(1,1,1,1) twice; STORE reg0 → rows 8,6,4,2 (all lanes). `opc_c_valid` and `opc_ab_valid` never both high.
- STORE with `out_ready` low 5 cycles on row 0 → `out_row` stable, no `opc_c_valid`, rows intact after release.
- MAC len 0 → `done` at T+1, no strobes. LOAD with `in_valid` gaps of 3 cycles → correct rows, `done` after the last beat +1.
- Reset after 1 of 3 MAC beats → next cycle all strobes 0, `busy`=0, `cmd_ready`=1, no `done`.
- Back-to-back commands: `cmd_valid` held high → each accepted the cycle after `done`, with correct tile addresses.
